// File: rtl/note_recorder_pkg.sv
// Shared note-byte constants, FSM encoding and note decode helper for the bar recorder.
// The song player reads bars in this same note-byte format.
package note_recorder_pkg;

  localparam int unsigned NOTE_W               = 8;
  localparam int unsigned DIV_W                = 3;
  localparam int unsigned NUM_ROWS_PER_BAR_DEF = 16;
  localparam int unsigned IDX_W_DEF            = 8;

  localparam logic [7:0] NOTE_REST = 8'h00;
  localparam logic [3:0] NOTE_C    = 4'd1;
  localparam logic [3:0] NOTE_CS   = 4'd2;
  localparam logic [3:0] NOTE_D    = 4'd3;
  localparam logic [3:0] NOTE_DS   = 4'd4;
  localparam logic [3:0] NOTE_E    = 4'd5;
  localparam logic [3:0] NOTE_F    = 4'd6;
  localparam logic [3:0] NOTE_FS   = 4'd7;
  localparam logic [3:0] NOTE_G    = 4'd8;
  localparam logic [3:0] NOTE_GS   = 4'd9;
  localparam logic [3:0] NOTE_A    = 4'd10;
  localparam logic [3:0] NOTE_AS   = 4'd11;
  localparam logic [3:0] NOTE_B    = 4'd12;
  localparam logic [3:0] NOTE_MAX  = NOTE_B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RECORD = 2'd2
  } rec_state_e;

  typedef struct packed {
    logic [3:0] note;
    logic [3:0] octave;
  } note_byte_t;

  // A pitch nibble outside C..B cannot be played back, so it is never stored.
  function automatic logic is_valid_note(input note_byte_t n);
    return (n.note != 4'd0) && (n.note <= NOTE_MAX);
  endfunction

endpackage

// File: rtl/note_recorder_tick_div.sv
// row_tick_divider: turns row strobes into row advances.
// NOTE_RECORDER_TICK_DIV_EN selects a divide-by-8 grid; otherwise every tick advances.
module row_tick_divider
  import note_recorder_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_clr,
  output logic o_row_adv_c
);

`ifdef NOTE_RECORDER_TICK_DIV_EN
  logic [DIV_W-1:0] r_div;

  // Advance on the tick seen while the divider sits at zero, matching the player's tick_timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (i_clr) begin
      r_div <= '0;
    end else if (i_tick) begin
      r_div <= DIV_W'(r_div + 1'b1);
    end
  end

  assign o_row_adv_c = i_tick && (r_div == '0);
`else
  logic w_unused_ok;

  assign w_unused_ok = &{1'b0, clk, rst_n, i_clr};
  assign o_row_adv_c = i_tick;
`endif

endmodule

// File: rtl/note_recorder.sv
// note_recorder: quantises live note events into one bar of row bytes for the bar RAM.
// Optional divided row grid via NOTE_RECORDER_TICK_DIV_EN (see row_tick_divider).
module note_recorder
  import note_recorder_pkg::*;
#(
  parameter int unsigned NUM_ROWS_PER_BAR = NUM_ROWS_PER_BAR_DEF,
  parameter int unsigned IDX_W            = IDX_W_DEF
) (
  input  logic              main_clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              arm,
  input  logic [IDX_W-1:0]  bar_sel,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [NOTE_W-1:0] note_in,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_bar_idx,
  output logic [IDX_W-1:0]  wr_row_idx,
  output logic [NOTE_W-1:0] wr_note,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              bad_note
);

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NUM_ROWS_PER_BAR - 1);

  rec_state_e r_state;
  rec_state_e w_next_state;

  logic              w_row_adv;
  logic              w_last_row;
  logic              w_start;
  logic              w_close;
  logic              w_take;
  logic              w_good;
  logic              w_fill;
  logic              w_dup;

  logic [IDX_W-1:0]  r_row;
  logic [NOTE_W-1:0] r_slot;
  logic              r_slot_full;
  logic              r_note_ready;
  logic              r_wr_en;
  logic [IDX_W-1:0]  r_wr_bar_idx;
  logic [IDX_W-1:0]  r_wr_row_idx;
  logic [NOTE_W-1:0] r_wr_note;
  logic              r_busy;
  logic              r_done;
  logic              r_overrun;
  logic              r_bad_note;

  row_tick_divider u_div (
    .clk         (main_clk),
    .rst_n       (rst_n),
    .i_tick      (tick),
    .i_clr       (w_start),
    .o_row_adv_c (w_row_adv)
  );

  assign w_last_row = (r_row == LAST_ROW);
  assign w_good     = is_valid_note(note_byte_t'(note_in));

  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:   if (arm)                     w_next_state = ST_ARMED;
      ST_ARMED:  if (w_row_adv)               w_next_state = ST_RECORD;
      ST_RECORD: if (w_row_adv && w_last_row) w_next_state = ST_IDLE;
      default:                                w_next_state = ST_IDLE;
    endcase
  end

  // A note offered on the closing cycle goes to the fresh slot of the next row.
  always_comb begin
    w_start = 1'b0;
    w_close = 1'b0;
    w_take  = 1'b0;
    unique case (r_state)
      ST_IDLE:   w_start = arm;
      ST_RECORD: begin
        w_close = w_row_adv;
        w_take  = note_valid;
      end
      default: ;
    endcase
    w_fill = w_take && w_good && (w_close || !r_slot_full);
    w_dup  = w_take && w_good && !w_close && r_slot_full;
  end

  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row        <= '0;
      r_slot       <= NOTE_REST;
      r_slot_full  <= 1'b0;
      r_note_ready <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_bar_idx <= '0;
      r_wr_row_idx <= '0;
      r_wr_note    <= NOTE_REST;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
      r_bad_note   <= 1'b0;
    end else begin
      r_note_ready <= (w_next_state == ST_RECORD);
      r_busy       <= (w_next_state != ST_IDLE);
      r_wr_en      <= w_close;
      r_done       <= w_close && w_last_row;

      if (w_start) begin
        r_wr_bar_idx <= bar_sel;
        r_row        <= '0;
        r_slot       <= NOTE_REST;
        r_slot_full  <= 1'b0;
        r_overrun    <= 1'b0;
        r_bad_note   <= 1'b0;
      end else begin
        if (w_take && !w_good) r_bad_note <= 1'b1;
        if (w_dup)             r_overrun  <= 1'b1;

        if (w_close) begin
          r_wr_row_idx <= r_row;
          r_wr_note    <= r_slot;
          r_row        <= w_last_row ? '0 : IDX_W'(r_row + 1'b1);
          r_slot       <= w_fill ? note_in : NOTE_REST;
          r_slot_full  <= w_fill;
        end else if (w_fill) begin
          r_slot      <= note_in;
          r_slot_full <= 1'b1;
        end
      end
    end
  end

  assign note_ready = r_note_ready;
  assign wr_en      = r_wr_en;
  assign wr_bar_idx = r_wr_bar_idx;
  assign wr_row_idx = r_wr_row_idx;
  assign wr_note    = r_wr_note;
  assign busy       = r_busy;
  assign done       = r_done;
  assign overrun    = r_overrun;
  assign bad_note   = r_bad_note;

endmodule

// File: tb/tb_note_recorder.sv
// Self-checking bench for note_recorder: per-scenario tasks, random bars vs. a row-list model.
module tb_note_recorder;

`ifdef NOTE_RECORDER_TICK_DIV_EN
  localparam int TPR = 8;
`else
  localparam int TPR = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       arm = 1'b0;
  logic [7:0] bar_sel = 8'd0;
  logic       note_valid = 1'b0;
  logic       note_ready;
  logic [7:0] note_in = 8'd0;
  logic       wr_en;
  logic [7:0] wr_bar_idx;
  logic [7:0] wr_row_idx;
  logic [7:0] wr_note;
  logic       busy;
  logic       done;
  logic       overrun;
  logic       bad_note;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] bar;
    logic [7:0] row;
    logic [7:0] note;
    logic       done;
  } wr_t;

  wr_t wq[$];
  int  done_cnt = 0;

  // Per-row plan: notes offered inside row r, plus one note offered on the tick closing row r.
  logic [7:0] rn[16][4];
  int         rc[16];
  logic [7:0] co[16];
  logic [7:0] exp_note[16];
  bit         exp_ovr;
  bit         exp_bad;

  note_recorder dut (
    .main_clk   (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .arm        (arm),
    .bar_sel    (bar_sel),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_in    (note_in),
    .wr_en      (wr_en),
    .wr_bar_idx (wr_bar_idx),
    .wr_row_idx (wr_row_idx),
    .wr_note    (wr_note),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .bad_note   (bad_note)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) wq.push_back('{bar: wr_bar_idx, row: wr_row_idx, note: wr_note, done: done});
    if (done) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit good(input logic [7:0] n);
    return (n[7:4] >= 4'd1) && (n[7:4] <= 4'd12);
  endfunction

  // Reference: each row's offered notes in order; first playable one wins.
  function automatic void build_expect();
    logic [7:0] lst[$];
    exp_ovr = 1'b0;
    exp_bad = 1'b0;
    for (int r = 0; r < 16; r++) begin
      lst.delete();
      if (r > 0 && co[r-1] != 8'h00) lst.push_back(co[r-1]);
      for (int k = 0; k < rc[r]; k++) lst.push_back(rn[r][k]);
      exp_note[r] = 8'h00;
      foreach (lst[i]) begin
        if (!good(lst[i]))              exp_bad = 1'b1;
        else if (exp_note[r] == 8'h00)  exp_note[r] = lst[i];
        else                            exp_ovr = 1'b1;
      end
    end
  endfunction

  task automatic clear_plan();
    for (int r = 0; r < 16; r++) begin
      rc[r] = 0;
      co[r] = 8'h00;
    end
  endtask

  task automatic arm_bar(input logic [7:0] b);
    bar_sel = b;
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    bar_sel = 8'd0;
    cyc();
  endtask

  task automatic adv(input logic [7:0] n);
    for (int i = 0; i < TPR; i++) begin
      tick = 1'b1;
      if (i == 0 && n != 8'h00) begin
        note_valid = 1'b1;
        note_in = n;
      end
      cyc();
      tick = 1'b0;
      note_valid = 1'b0;
      note_in = 8'h00;
    end
  endtask

  task automatic play(input logic [7:0] b, input int nrows);
    wq.delete();
    done_cnt = 0;
    arm_bar(b);
    adv(8'h00);
    for (int r = 0; r < nrows; r++) begin
      for (int k = 0; k < rc[r]; k++) begin
        note_valid = 1'b1;
        note_in = rn[r][k];
        cyc();
        note_valid = 1'b0;
        note_in = 8'h00;
      end
      adv(co[r]);
    end
    repeat (3) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick = i[0];
      note_valid = ~i[0];
      arm = i[1];
      note_in = 8'h35;
      @(negedge clk);
      n_checks++;
      if ({note_ready, wr_en, wr_bar_idx, wr_row_idx, wr_note, busy, done, overrun, bad_note} !== 36'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %b required all zero", i,
                 {note_ready, wr_en, wr_bar_idx, wr_row_idx, wr_note, busy, done, overrun, bad_note});
      end
    end
    tick = 1'b0; note_valid = 1'b0; arm = 1'b0; note_in = 8'h00;
    cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    n_checks++;
    if (wq.size() !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_write: writes=%0d busy=%b required 0 and 0", wq.size(), busy);
    end
  endtask

  task automatic test_basic_bar();
    clear_plan();
    rn[0][0] = 8'h13; rc[0] = 1;
    build_expect();
    play(8'd3, 16);
    n_checks++;
    if (wq.size() !== 16) begin
      n_fail++;
      $display("FAIL basic_count: got %0d writes required 16", wq.size());
    end
    for (int r = 0; r < wq.size() && r < 16; r++) begin
      n_checks++;
      if (wq[r] !== {8'd3, 8'(r), exp_note[r], 1'(r == 15)}) begin
        n_fail++;
        $display("FAIL basic_row%0d: got bar=%h row=%h note=%h done=%b required bar=03 row=%h note=%h done=%b",
                 r, wq[r].bar, wq[r].row, wq[r].note, wq[r].done, 8'(r), exp_note[r], r == 15);
      end
    end
    n_checks++;
    if (done_cnt !== 1 || busy !== 1'b0 || note_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end: done_pulses=%0d busy=%b ready=%b required 1 0 0", done_cnt, busy, note_ready);
    end
  endtask

  task automatic test_overrun();
    clear_plan();
    rn[2][0] = 8'h52; rn[2][1] = 8'hA4; rc[2] = 2;
    build_expect();
    play(8'd5, 16);
    n_checks++;
    if (wq.size() !== 16 || wq[2].note !== 8'h52 || overrun !== exp_ovr || exp_ovr !== 1'b1 || bad_note !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_set: writes=%0d row2=%h overrun=%b bad=%b required 16 52 1 0",
               wq.size(), wq[2].note, overrun, bad_note);
    end
    arm_bar(8'd1);
    n_checks++;
    if (overrun !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_clear: overrun=%b busy=%b required 0 1", overrun, busy);
    end
    repeat (17) adv(8'h00);
    repeat (2) cyc();
  endtask

  task automatic test_coincident();
    clear_plan();
    rn[4][0] = 8'h31; rc[4] = 1;
    co[4] = 8'hC5;
    build_expect();
    play(8'd7, 16);
    n_checks++;
    if (wq.size() !== 16 || wq[4].note !== 8'h31 || wq[5].note !== 8'hC5 || wq[5].note !== exp_note[5]) begin
      n_fail++;
      $display("FAIL coincident: writes=%0d row4=%h row5=%h required 16 31 c5", wq.size(), wq[4].note, wq[5].note);
    end
    n_checks++;
    if (overrun !== 1'b0 || wq[3].note !== 8'h00 || wq[6].note !== 8'h00) begin
      n_fail++;
      $display("FAIL coincident_neighbours: overrun=%b row3=%h row6=%h required 0 00 00",
               overrun, wq[3].note, wq[6].note);
    end
  endtask

  task automatic test_bad_note();
    clear_plan();
    rn[6][0] = 8'hD3; rn[6][1] = 8'h03; rc[6] = 2;
    build_expect();
    play(8'd9, 16);
    n_checks++;
    if (wq.size() !== 16 || wq[6].note !== 8'h00 || bad_note !== 1'b1 || exp_bad !== 1'b1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_note: writes=%0d row6=%h bad=%b overrun=%b required 16 00 1 0",
               wq.size(), wq[6].note, bad_note, overrun);
    end
  endtask

  task automatic test_reset_mid_bar();
    clear_plan();
    rn[1][0] = 8'h24; rc[1] = 1;
    build_expect();
    play(8'd2, 8);
    rst_n = 1'b0;
    cyc();
    n_checks++;
    if (busy !== 1'b0 || note_ready !== 1'b0 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: busy=%b ready=%b wr_en=%b required 0 0 0", busy, note_ready, wr_en);
    end
    repeat (4) adv(8'h00);
    rst_n = 1'b1;
    repeat (4) adv(8'h46);
    repeat (2) cyc();
    n_checks++;
    if (wq.size() !== 8 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_writes: got %0d writes busy=%b required 8 0", wq.size(), busy);
    end
    for (int r = 0; r < wq.size() && r < 8; r++) begin
      n_checks++;
      if (wq[r] !== {8'd2, 8'(r), exp_note[r], 1'b0}) begin
        n_fail++;
        $display("FAIL midreset_row%0d: got row=%h note=%h required row=%h note=%h",
                 r, wq[r].row, wq[r].note, 8'(r), exp_note[r]);
      end
    end
  endtask

  task automatic test_random_bars();
    logic [7:0] b;
    for (int t = 0; t < 4; t++) begin
      clear_plan();
      for (int r = 0; r < 16; r++) begin
        rc[r] = $urandom_range(0, 3);
        for (int k = 0; k < rc[r]; k++) rn[r][k] = {4'($urandom_range(1, 12)), 4'($urandom_range(0, 15))};
        if (r < 15 && $urandom_range(0, 3) == 0) co[r] = {4'($urandom_range(1, 12)), 4'($urandom_range(0, 15))};
      end
      build_expect();
      b = 8'($urandom_range(0, 255));
      play(b, 16);
      n_checks++;
      if (wq.size() !== 16 || done_cnt !== 1) begin
        n_fail++;
        $display("FAIL rand%0d_count: writes=%0d done=%0d required 16 1", t, wq.size(), done_cnt);
      end
      for (int r = 0; r < wq.size() && r < 16; r++) begin
        n_checks++;
        if (wq[r] !== {b, 8'(r), exp_note[r], 1'(r == 15)}) begin
          n_fail++;
          $display("FAIL rand%0d_row%0d: got bar=%h row=%h note=%h done=%b required bar=%h note=%h",
                   t, r, wq[r].bar, wq[r].row, wq[r].note, wq[r].done, b, exp_note[r]);
        end
      end
      n_checks++;
      if (overrun !== exp_ovr || bad_note !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_flags: overrun=%b bad=%b required %b 0", t, overrun, bad_note, exp_ovr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_bar();
    test_overrun();
    test_coincident();
    test_bad_note();
    test_reset_mid_bar();
    test_random_bars();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
